// File: rtl/contador_gray_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : contador_gray_detector_pkg
// Purpose  : Shared widths, default detection codes and the binary-to-Gray
//            helper for the Gray counter / transition detector.
// Contents : GRAY_W        default counter width
//            PREV_CODE_DEF Gray code expected in the previous state (0100)
//            CURR_CODE_DEF Gray code expected in the current state  (1100)
//            bin2gray()    b ^ (b >> 1) at GRAY_W bits
// Revision : 1.0 - initial release
// ============================================================================
package contador_gray_detector_pkg;

  localparam int GRAY_W = 4;

  // Binary 7 -> 8 seen in Gray space.
  localparam logic [GRAY_W-1:0] PREV_CODE_DEF = 4'b0100;
  localparam logic [GRAY_W-1:0] CURR_CODE_DEF = 4'b1100;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/contador_gray_detector_bin2gray.sv
`default_nettype none
// ============================================================================
// Module   : bin2gray
// Purpose  : Combinational binary-to-reflected-Gray converter.
// Ports    : bin  in  WIDTH  binary value
//            gray out WIDTH  Gray-coded value, bin ^ (bin >> 1)
// Revision : 1.0 - initial release
// ============================================================================
module bin2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule
`default_nettype wire

// File: rtl/contador_gray_detector.sv
`default_nettype none
// ============================================================================
// Module   : contador_gray_detector
// Purpose  : Gray-code counter that advances one code per enabled clock and
//            flags the PREV_CODE -> CURR_CODE step (binary 7 -> 8 by default).
// Ports    : clk       in   1      rising-edge clock
//            rst       in   1      synchronous reset, active-high
//            enable    in   1      1 = advance on this edge, 0 = hold
//            gray_out  out  WIDTH  registered Gray count
//            detector  out  1      gray_anterior==PREV_CODE && gray_out==CURR_CODE
// Revision : 1.0 - initial release
// ============================================================================
module contador_gray_detector
  import contador_gray_detector_pkg::*;
#(
  parameter int               WIDTH     = GRAY_W,
  parameter logic [WIDTH-1:0] PREV_CODE = PREV_CODE_DEF,
  parameter logic [WIDTH-1:0] CURR_CODE = CURR_CODE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] gray_out,
  output logic             detector
);

  logic [WIDTH-1:0] bin_cnt;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic [WIDTH-1:0] gray_anterior;

  // Modulo 2^WIDTH: the 15 -> 0 wrap falls out of the truncated add.
  assign bin_next = bin_cnt + WIDTH'(1);

  bin2gray #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin  (bin_next),
    .gray (gray_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt       <= '0;
      gray_out      <= '0;
      gray_anterior <= '0;
    end else if (enable) begin
      bin_cnt       <= bin_next;
      gray_out      <= gray_next;
      gray_anterior <= gray_out;
    end
  end

  // Purely combinational from the two registers, so the flag is valid in the
  // same cycle gray_out reaches CURR_CODE and stays up while the count holds.
  assign detector = (gray_anterior == PREV_CODE) && (gray_out == CURR_CODE);

endmodule
`default_nettype wire

// File: tb/tb_contador_gray_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_gray_detector
// Purpose  : Directed, scoreboard-based bench for contador_gray_detector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_contador_gray_detector;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] gray_out;
  logic       detector;

  contador_gray_detector dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .gray_out (gray_out),
    .detector (detector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] cur;
    logic [3:0] prev;
    logic [3:0] nxt;
    logic       det;
    logic       adv;
  } exp_t;

  exp_t q[$];

  logic [3:0] seq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                           4'b0110, 4'b0111, 4'b0101, 4'b0100,
                           4'b1100, 4'b1101, 4'b1111, 4'b1110,
                           4'b1010, 4'b1011, 4'b1001, 4'b1000};

  int         total = 0;
  int         bad   = 0;
  int         m_idx = 0;
  logic [3:0] m_cur = 4'b0000;
  logic [3:0] m_prev = 4'b0000;
  logic [3:0] last_obs = 4'b0000;
  int         det_count = 0;

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of stimulus, push the model's prediction, then compare
  // everything the DUT shows 1 time unit after the edge.
  task automatic step(input logic r, input logic e);
    exp_t x;
    exp_t got;
    rst    = r;
    enable = e;
    if (r) begin
      m_idx  = 0;
      m_cur  = 4'b0000;
      m_prev = 4'b0000;
    end else if (e) begin
      m_prev = m_cur;
      m_idx  = (m_idx + 1) % 16;
      m_cur  = seq[m_idx];
    end
    x.cur  = m_cur;
    x.prev = m_prev;
    x.nxt  = seq[(m_idx + 1) % 16];
    x.det  = (m_prev == 4'b0100) && (m_cur == 4'b1100);
    x.adv  = !r && e;
    q.push_back(x);
    @(posedge clk);
    #1;
    got = q.pop_front();
    check4("gray_out", gray_out, got.cur);
    check4("gray_anterior", dut.gray_anterior, got.prev);
    check4("gray_next", dut.gray_next, got.nxt);
    check1("detector", detector, got.det);
    if (got.adv) begin
      total++;
      assert ($countones(gray_out ^ last_obs) == 1) else begin
        bad++;
        $error("FAIL hamming observed=%0d expected=1 (%b -> %b)",
               $countones(gray_out ^ last_obs), last_obs, gray_out);
      end
    end
    if (detector === 1'b1) det_count++;
    last_obs = gray_out;
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;

    // Reset for two clocks with enable low.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Continuous count: 8th edge hits 1100, wrap at the 16th, into the next lap.
    det_count = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    total++;
    assert (det_count == 1) else begin
      bad++;
      $error("FAIL det_pulses observed=%0d expected=1", det_count);
    end

    // Hold three clocks mid-count, then resume without a skip.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);   // now at 1100

    // Hold at 1100: detector stays up.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);                               // 1101, detector drops

    // Return to 1100 and reset while detector is high (reset beats enable).
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    // Count to 1000 and reset there.
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // A full lap plus the wrap; exactly one pulse expected.
    det_count = 0;
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1);
    total++;
    assert (det_count == 1) else begin
      bad++;
      $error("FAIL det_pulses_lap observed=%0d expected=1", det_count);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
